// File: rtl/axil_wr_arb_if.sv
// AXI-Lite write-only channel bundle (AW, W, B) between the arbiter and a slave.
interface axil_wr_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axil_wr_arb.sv
// Two-requester round-robin arbiter issuing single AXI-Lite writes.
// All outputs come straight from flops; one transaction in flight at a time.
module axil_wr_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic [1:0]            i_req,
  input  logic [ADDR_W-1:0]     i_addr0,
  input  logic [ADDR_W-1:0]     i_addr1,
  input  logic [DATA_W-1:0]     i_din0,
  input  logic [DATA_W-1:0]     i_din1,
  input  logic [DATA_W/8-1:0]   i_strb0,
  input  logic [DATA_W/8-1:0]   i_strb1,
  output logic [1:0]            o_ack,
  output logic [1:0]            o_done,
  output logic [1:0]            o_resp,
  output logic                  o_busy,
  axil_wr_arb_if.master         m_axi
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_RESP  = 2'b10;

  logic [1:0]            state_r;
  logic                  awvalid_r;
  logic                  wvalid_r;
  logic                  bready_r;
  logic [ADDR_W-1:0]     awaddr_r;
  logic [DATA_W-1:0]     wdata_r;
  logic [DATA_W/8-1:0]   wstrb_r;
  logic [1:0]            ack_r;
  logic [1:0]            done_r;
  logic [1:0]            resp_r;
  logic                  busy_r;
  logic                  gnt_r;
  logic                  last_g_r;

  logic                  gnt_valid_s;
  logic                  gnt_id_s;
  logic [ADDR_W-1:0]     sel_addr_s;
  logic [DATA_W-1:0]     sel_din_s;
  logic [DATA_W/8-1:0]   sel_strb_s;
  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  aw_fin_s;
  logic                  w_fin_s;

  // Arbitration: a lone request always wins; a tie goes to whoever was not served last.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    case (i_req)
      2'b01: begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b0;
      end
      2'b10: begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b1;
      end
      2'b11: begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = ~last_g_r;
      end
      default: begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = 1'b0;
      end
    endcase
  end

  // Payload mux for the requester being granted.
  always_comb begin
    sel_addr_s = i_addr0;
    sel_din_s  = i_din0;
    sel_strb_s = i_strb0;
    if (gnt_id_s) begin
      sel_addr_s = i_addr1;
      sel_din_s  = i_din1;
      sel_strb_s = i_strb1;
    end else begin
      sel_addr_s = i_addr0;
      sel_din_s  = i_din0;
      sel_strb_s = i_strb0;
    end
  end

  // A channel is finished once its valid has already dropped or handshakes now.
  assign aw_hs_s  = awvalid_r & m_axi.awready;
  assign w_hs_s   = wvalid_r & m_axi.wready;
  assign aw_fin_s = ~awvalid_r | aw_hs_s;
  assign w_fin_s  = ~wvalid_r | w_hs_s;

  // Transaction FSM and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_r   <= ST_IDLE;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      awaddr_r  <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      wstrb_r   <= {(DATA_W/8){1'b0}};
      ack_r     <= 2'b00;
      done_r    <= 2'b00;
      resp_r    <= 2'b00;
      busy_r    <= 1'b0;
      gnt_r     <= 1'b0;
      last_g_r  <= 1'b1;
    end else begin
      ack_r  <= 2'b00;
      done_r <= 2'b00;
      case (state_r)
        ST_IDLE: begin
          if (gnt_valid_s) begin
            awaddr_r  <= sel_addr_s;
            wdata_r   <= sel_din_s;
            wstrb_r   <= sel_strb_s;
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            ack_r     <= gnt_id_s ? 2'b10 : 2'b01;
            gnt_r     <= gnt_id_s;
            busy_r    <= 1'b1;
            state_r   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
          end
          if (aw_fin_s && w_fin_s) begin
            bready_r <= 1'b1;
            state_r  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (m_axi.bvalid && bready_r) begin
            bready_r <= 1'b0;
            resp_r   <= m_axi.bresp;
            done_r   <= gnt_r ? 2'b10 : 2'b01;
            last_g_r <= gnt_r;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign m_axi.awvalid = awvalid_r;
  assign m_axi.awaddr  = awaddr_r;
  assign m_axi.wvalid  = wvalid_r;
  assign m_axi.wdata   = wdata_r;
  assign m_axi.wstrb   = wstrb_r;
  assign m_axi.bready  = bready_r;
  assign o_ack         = ack_r;
  assign o_done        = done_r;
  assign o_resp        = resp_r;
  assign o_busy        = busy_r;

endmodule

// File: tb/tb_axil_wr_arb.sv
// Scoreboard bench for axil_wr_arb: stimulus pushes expected grants/payloads/responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_axil_wr_arb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        req = 2'b00;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] din0 = '0, din1 = '0;
  logic [STRB_W-1:0] strb0 = '0, strb1 = '0;
  logic [1:0]        ack, done, resp;
  logic              busy;

  axil_wr_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axil_wr_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_req(req),
    .i_addr0(addr0), .i_addr1(addr1), .i_din0(din0), .i_din1(din1),
    .i_strb0(strb0), .i_strb1(strb1),
    .o_ack(ack), .o_done(done), .o_resp(resp), .o_busy(busy),
    .m_axi(axi)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [1:0] bresp_val = 2'b00;

  int                       ack_q[$];
  logic [ADDR_W-1:0]        aw_q[$];
  logic [DATA_W+STRB_W-1:0] w_q[$];
  logic [2:0]               done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_txn(input int id, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [STRB_W-1:0] s, input logic [1:0] r);
    logic [0:0] idb;
    idb = id[0];
    ack_q.push_back(id);
    aw_q.push_back(a);
    w_q.push_back({d, s});
    done_q.push_back({idb, r});
  endtask

  // Slave AW/W/B channel models, driven 2 time units after each rising edge.
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  initial begin
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      if (!resetn) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else begin
        if (axi.awvalid && !axi.awready) begin
          if (aw_cnt >= aw_delay) axi.awready = 1'b1; else aw_cnt++;
        end else begin
          axi.awready = 1'b0; aw_cnt = 0;
        end
        if (axi.wvalid && !axi.wready) begin
          if (w_cnt >= w_delay) axi.wready = 1'b1; else w_cnt++;
        end else begin
          axi.wready = 1'b0; w_cnt = 0;
        end
        if (axi.bvalid) begin
          axi.bvalid = 1'b0; b_cnt = 0;
        end else if (axi.bready) begin
          if (b_cnt >= b_delay) begin
            axi.bvalid = 1'b1; axi.bresp = bresp_val;
          end else b_cnt++;
        end else b_cnt = 0;
      end
    end
  end

  // Monitor: compare every DUT-presented output against the scoreboard queues.
  logic [1:0] prev_ack = 2'b00;
  logic       prev_bready = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_ack = 2'b00; prev_bready = 1'b0;
      end else begin
        if (ack != 2'b00) begin
          logic [1:0] e;
          e = 2'b00;
          if (ack_q.size() != 0) e = 2'b01 << ack_q.pop_front();
          check("ack", {prev_ack, ack}, {2'b00, e});
        end
        if (axi.awvalid) begin
          if (aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
          else begin
            check("awaddr", axi.awaddr, aw_q[0]);
            if (axi.awready) void'(aw_q.pop_front());
          end
        end
        if (axi.wvalid) begin
          if (w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
          else begin
            check("wdata_wstrb", {axi.wdata, axi.wstrb}, w_q[0]);
            if (axi.wready) void'(w_q.pop_front());
          end
        end
        if (axi.bready && !prev_bready) check("bready_early", {axi.awvalid, axi.wvalid}, 64'd0);
        if (done != 2'b00) begin
          if (done_q.size() == 0) check("done_unexpected", done, 64'd0);
          else begin
            logic [2:0] e;
            logic [1:0] eid;
            e = done_q.pop_front();
            eid = e[2] ? 2'b10 : 2'b01;
            check("done_id", done, eid);
            check("resp", resp, e[1:0]);
          end
        end
        prev_ack = ack; prev_bready = axi.bready;
      end
    end
  end

  task automatic flush();
    ack_q.delete(); aw_q.delete(); w_q.delete(); done_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; req = 2'b00;
    flush();
    repeat (2) @(negedge clk);
    check("reset_ctrl", {axi.awvalid, axi.wvalid, axi.bready, ack, done, resp, busy}, 64'd0);
    check("reset_data", {axi.awaddr, axi.wdata}, 64'd0);
    check("reset_strb", axi.wstrb, 64'd0);
    resetn = 1'b1;
  endtask

  // Drive one requester until its grant; returns cycles waited for o_ack.
  task automatic issue(input int id, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [STRB_W-1:0] s, output int waited);
    if (id == 0) begin addr0 = a; din0 = d; strb0 = s; req[0] = 1'b1; end
    else begin addr1 = a; din1 = d; strb1 = s; req[1] = 1'b1; end
    push_txn(id, a, d, s, bresp_val);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (ack[id] !== 1'b1 && waited < 20);
    check("ack_timeout", (ack[id] === 1'b1) ? 64'd1 : 64'd0, 64'd1);
    req[id] = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int i;
    i = 0;
    while (done_q.size() != 0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", done_q.size(), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, done_cyc;
    do_reset();

    // Single write from requester 0, one-cycle latency to valid/ack.
    issue(0, 32'h10, 32'h5, 4'hF, w);
    check("latency", w, 64'd1);
    check("awvalid_after_grant", {axi.awvalid, axi.wvalid}, 64'h3);
    wait_drain(50);

    // Contention after reset: grants alternate 0,1,0,1.
    do_reset();
    addr0 = 32'hA0; din0 = 32'h1111; strb0 = 4'hF;
    addr1 = 32'hB0; din1 = 32'h2222; strb1 = 4'h3;
    push_txn(0, 32'hA0, 32'h1111, 4'hF, 2'b00);
    push_txn(1, 32'hB0, 32'h2222, 4'h3, 2'b00);
    push_txn(0, 32'hA0, 32'h1111, 4'hF, 2'b00);
    push_txn(1, 32'hB0, 32'h2222, 4'h3, 2'b00);
    @(negedge clk);
    req = 2'b11;
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (done != 2'b00) n++;
      if (n == 4) req = 2'b00;
    end
    req = 2'b00;
    check("contention_count", n, 64'd4);
    wait_drain(50);

    // Skewed handshakes: address first, then data first.
    aw_delay = 0; w_delay = 3;
    issue(0, 32'h1234, 32'hCAFE_F00D, 4'h5, w);
    wait_drain(50);
    aw_delay = 3; w_delay = 0;
    issue(1, 32'h5678, 32'hDEAD_BEEF, 4'hA, w);
    wait_drain(50);
    aw_delay = 0; w_delay = 0;

    // SLVERR is reported unchanged, next request is normal.
    bresp_val = 2'b10;
    issue(0, 32'h40, 32'h77, 4'h1, w);
    wait_drain(50);
    bresp_val = 2'b00;
    issue(1, 32'h44, 32'h88, 4'h2, w);
    wait_drain(50);

    // Back-to-back from requester 1: ack exactly one cycle after each done.
    addr1 = 32'hC0; din1 = 32'h9; strb1 = 4'hC;
    for (int i = 0; i < 3; i++) push_txn(1, 32'hC0, 32'h9, 4'hC, 2'b00);
    @(negedge clk);
    req = 2'b10;
    n = 0; done_cyc = -1;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(negedge clk);
      if (ack[1] && done_cyc >= 0) check("b2b_gap", cyc - done_cyc, 64'd1);
      if (done[1]) begin
        n++; done_cyc = cyc;
        if (n == 3) req = 2'b00;
      end
    end
    req = 2'b00;
    check("b2b_count", n, 64'd3);
    wait_drain(50);

    // Reset while waiting in RESP: abort without done, then requester 0 wins the tie.
    b_delay = 20;
    issue(1, 32'hE0, 32'hE1, 4'hF, w);
    n = 0;
    while (!axi.bready && n < 20) begin @(negedge clk); n++; end
    check("reach_resp", axi.bready, 64'd1);
    resetn = 1'b0;
    flush();
    req = 2'b11;
    addr0 = 32'hF0; din0 = 32'hF1; strb0 = 4'h9;
    @(negedge clk);
    check("abort_outputs", {axi.awvalid, axi.wvalid, axi.bready, ack, done, resp, busy}, 64'd0);
    check("abort_data", {axi.awaddr, axi.wdata, axi.wstrb}, 64'd0);
    b_delay = 0;
    push_txn(0, 32'hF0, 32'hF1, 4'h9, 2'b00);
    resetn = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (ack == 2'b00 && n < 20);
    check("post_reset_grant", ack, 64'h1);
    req = 2'b00;
    wait_drain(50);

    check("queues_empty", ack_q.size() + aw_q.size() + w_q.size() + done_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axil_wr_arb.md
AXIL_WR_ARB -- requirements
Module: axil_wr_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI-Lite data width; strobe width is DATA_W/8.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_req  input  2  per-requester write request, level; bit n = requester n.
REQ-006 SHALL have ports i_addr0/i_addr1  input  ADDR_W each  requester write address.
REQ-007 SHALL have ports i_din0/i_din1  input  DATA_W each  requester write data.
REQ-008 SHALL have ports i_strb0/i_strb1  input  DATA_W/8 each  requester byte strobes.
REQ-009 SHALL have port o_ack  output  2  one-cycle pulse: request n captured (granted).
REQ-010 SHALL have port o_done  output  2  one-cycle pulse: requester n write response received.
REQ-011 SHALL have port o_resp  output  2  BRESP of the most recently completed write.
REQ-012 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have ports m_axi_awvalid output 1, m_axi_awready input 1, m_axi_awaddr output ADDR_W: AXI-Lite write-address channel.
REQ-014 SHALL have ports m_axi_wvalid output 1, m_axi_wready input 1, m_axi_wdata output DATA_W, m_axi_wstrb output DATA_W/8: AXI-Lite write-data channel.
REQ-015 SHALL have ports m_axi_bvalid input 1, m_axi_bready output 1, m_axi_bresp input 2: AXI-Lite write-response channel.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, RESP; all outputs registered.
REQ-017 IDLE, i_req==0: SHALL stay IDLE, no outputs asserted.
REQ-018 IDLE, exactly one i_req bit set: SHALL grant that requester regardless of history.
REQ-019 IDLE, i_req==2'b11: SHALL grant the requester not served last (round-robin on register last_g).
REQ-020 On grant SHALL, at the same edge: latch granted addr/din/strb into m_axi_awaddr/wdata/wstrb, set awvalid=wvalid=1, pulse o_ack[g] for one cycle, go WRITE.
REQ-021 Latency: awvalid/wvalid high the cycle after i_req is sampled high in IDLE.
REQ-022 WRITE: awvalid SHALL drop the cycle after awvalid&&awready; wvalid independently the cycle after wvalid&&wready.
REQ-023 WRITE: awaddr/wdata/wstrb SHALL remain stable while the respective valid is high; valids never drop before handshake.
REQ-024 WRITE -> RESP when both handshakes complete, whether same cycle or in either order; bready set to 1 on that edge.
REQ-025 RESP: on bvalid&&bready SHALL clear bready, capture m_axi_bresp into o_resp, pulse o_done[g] one cycle, set last_g=g, go IDLE.
REQ-026 Non-OKAY bresp SHALL be reported via o_resp unchanged; no retry.
REQ-027 i_req changes while not IDLE SHALL be ignored; requester n drives its inputs valid until o_ack[n]; deasserting i_req before grant cancels with no transaction.
REQ-028 i_req[n] held high after o_done[n] SHALL be treated as a new request at the next IDLE cycle (minimum one IDLE cycle between transactions).
REQ-029 bvalid asserted outside RESP SHALL be ignored (bready=0).

Reset
REQ-030 While i_resetn==0 at a rising edge: state=IDLE, awvalid=wvalid=bready=0, o_ack=o_done=0, o_resp=0, o_busy=0, awaddr/wdata/wstrb=0, last_g=1 (requester 0 wins first tie).
REQ-031 Reset mid-transaction SHALL abort it immediately with no o_done pulse; arbitration restarts from REQ-030 values.

Verification
REQ-032 Single: i_req=01, addr0=0x10, din0=0x5, strb0=0xF, slave ready -> o_ack=01 next cycle, awaddr=0x10, wdata=0x5, then o_done=01, o_resp=0.
REQ-033 Contention: i_req=11 held for 4 transactions after reset -> grant order 0,1,0,1; each o_ack one cycle.
REQ-034 Skewed handshake: awready 3 cycles before wready (and reverse) -> awvalid drops after its handshake, data held stable, bready rises only after both.
REQ-035 Error: slave returns bresp=2'b10 -> o_resp=2'b10 with o_done pulse, next request served normally.
REQ-036 Reset in RESP (bvalid low) -> all outputs zero next cycle, no o_done; with i_req=11 post-reset requester 0 granted first.
REQ-037 Back-to-back: i_req=10 held -> consecutive transactions, exactly one IDLE cycle between o_done and next o_ack.
